// File: rtl/vedic_multiplier_pipelined_if.sv
// Operand/result bundle for the pipelined Vedic multiplier.
// The slave modport is the multiplier's view; the master modport is the producer/consumer side.
interface vedic_multiplier_pipelined_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic [WIDTH-1:0]   inData_A;
    logic [WIDTH-1:0]   inData_B;
    logic               in_signed;
    logic [TAG_W-1:0]   in_tag;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] outData_C;
    logic [TAG_W-1:0]   out_tag;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output inData_A, inData_B, in_signed, in_tag, in_valid, out_ready,
        input  in_ready, outData_C, out_tag, out_valid
    );

    modport slave (
        input  inData_A, inData_B, in_signed, in_tag, in_valid, out_ready,
        output in_ready, outData_C, out_tag, out_valid
    );
endinterface

// File: rtl/vedic_multiplier_pipelined.sv
// Pipelined Urdhva-Tiryagbhyam multiplier: 2x2 cells, then log2(WIDTH)-1 combine levels, sign fixed at the end.
// Latency log2(WIDTH) cycles; one op/cycle; the whole pipe freezes while the output is held by the consumer.
module vedic_multiplier_pipelined #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst,
    vedic_multiplier_pipelined_if.slave bus
);
    localparam int LAT = $clog2(WIDTH);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("vedic_multiplier_pipelined: WIDTH must be a power of two >= 2");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("vedic_multiplier_pipelined: TAG_W must be >= 1");
    end

    logic             advance;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_in;

    // Base 2x2 vertical-and-crosswise cell
    function automatic logic [3:0] cell2(input logic [1:0] a, input logic [1:0] b);
        logic lh, hl, hh, c;
        lh = a[0] & b[1];
        hl = a[1] & b[0];
        hh = a[1] & b[1];
        c  = lh & hl;
        return {hh & c, hh ^ c, lh ^ hl, a[0] & b[0]};
    endfunction

    // Magnitudes are WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1)
    always_comb begin
        mag_a  = (bus.in_signed && bus.inData_A[WIDTH-1]) ? -bus.inData_A : bus.inData_A;
        mag_b  = (bus.in_signed && bus.inData_B[WIDTH-1]) ? -bus.inData_B : bus.inData_B;
        neg_in = bus.in_signed & (bus.inData_A[WIDTH-1] ^ bus.inData_B[WIDTH-1]);
    end

    for (genvar l = 0; l < LAT; l++) begin : g_lvl
        localparam int DW   = 2 << l;
        localparam int PW   = 2 * DW;
        localparam int CNT  = WIDTH / DW;
        localparam bit LAST = (l == LAT - 1);

        logic [PW-1:0]    prod   [CNT*CNT];
        logic [PW-1:0]    prod_d [CNT*CNT];
        logic             vld;
        logic             vld_d;
        logic             neg_d;
        logic [TAG_W-1:0] tag;
        logic [TAG_W-1:0] tag_d;

        if (l == 0) begin : g_base
            always_comb begin
                vld_d = bus.in_valid;
                tag_d = bus.in_tag;
                neg_d = neg_in;
                for (int i = 0; i < CNT; i++) begin
                    for (int j = 0; j < CNT; j++) begin
                        prod_d[i*CNT+j] = cell2(mag_a[2*i +: 2], mag_b[2*j +: 2]);
                    end
                end
                if (LAST && neg_d) prod_d[0] = -prod_d[0];
            end
        end else begin : g_comb
            localparam int PCNT = 2 * CNT;
            // Four half-width products: low*low + (cross terms << DW/2) + high*high << DW
            always_comb begin
                vld_d = g_lvl[l-1].vld;
                tag_d = g_lvl[l-1].tag;
                neg_d = g_lvl[l-1].g_neg.neg;
                for (int i = 0; i < CNT; i++) begin
                    for (int j = 0; j < CNT; j++) begin
                        prod_d[i*CNT+j] =
                              PW'(g_lvl[l-1].prod[(2*i)*PCNT + 2*j])
                            + ((PW'(g_lvl[l-1].prod[(2*i)*PCNT + 2*j+1])
                              + PW'(g_lvl[l-1].prod[(2*i+1)*PCNT + 2*j])) << (DW/2))
                            + (PW'(g_lvl[l-1].prod[(2*i+1)*PCNT + 2*j+1]) << DW);
                    end
                end
                if (LAST && neg_d) prod_d[0] = -prod_d[0];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= 1'b0;
                tag <= '0;
                for (int k = 0; k < CNT*CNT; k++) prod[k] <= '0;
            end else if (advance) begin
                vld  <= vld_d;
                tag  <= tag_d;
                prod <= prod_d;
            end
        end

        if (!LAST) begin : g_neg
            logic neg;
            always_ff @(posedge clk) begin
                if (rst)          neg <= 1'b0;
                else if (advance) neg <= neg_d;
            end
        end
    end

    assign advance       = !bus.out_valid || bus.out_ready;
    assign bus.in_ready  = advance && !rst;
    assign bus.out_valid = g_lvl[LAT-1].vld;
    assign bus.out_tag   = g_lvl[LAT-1].tag;
    assign bus.outData_C = g_lvl[LAT-1].prod[0];
endmodule

// File: tb/tb_vedic_multiplier_pipelined.sv
// Scoreboard bench for the pipelined Vedic multiplier: directed cases then a long randomized run.
module tb_vedic_multiplier_pipelined;
    localparam int W   = 8;
    localparam int TW  = 4;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vedic_multiplier_pipelined_if #(.WIDTH(W), .TAG_W(TW)) bus ();
    vedic_multiplier_pipelined #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2*W-1:0] prod;
        logic [TW-1:0]  tag;
        int             cyc;
        int             stalls;
    } exp_t;

    exp_t           sb[$];
    int             checks    = 0;
    int             errors    = 0;
    int             cyc       = 0;
    int             stall_cnt = 0;
    bit             held_vld  = 1'b0;
    logic [2*W-1:0] held_dat;
    logic [TW-1:0]  held_tag;
    logic [2*W-1:0] last_out  = '0;
    bit             rnd_done  = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer multiply in the requested number system
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int x, y;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        return (2*W)'(x * y);
    endfunction

    // Monitor: captures accepted ops into the scoreboard and checks every emitted result
    always @(negedge clk) begin
        chk(bus.in_ready == ((!bus.out_valid || bus.out_ready) && !rst), "in_ready",
            32'(bus.in_ready), 32'((!bus.out_valid || bus.out_ready) && !rst));
        if (rst) begin
            sb.delete();
            held_vld = 1'b0;
        end else begin
            if (held_vld && bus.out_valid)
                chk(bus.outData_C == held_dat && bus.out_tag == held_tag, "stall_hold",
                    32'(bus.outData_C), 32'(held_dat));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "spurious_out", 32'(bus.outData_C), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk(bus.outData_C == e.prod, "product", 32'(bus.outData_C), 32'(e.prod));
                    chk(bus.out_tag == e.tag, "tag", 32'(bus.out_tag), 32'(e.tag));
                    chk(cyc - e.cyc == LAT + (stall_cnt - e.stalls), "latency",
                        32'(cyc - e.cyc), 32'(LAT + (stall_cnt - e.stalls)));
                    last_out = bus.outData_C;
                end
            end
            held_vld = bus.out_valid && !bus.out_ready;
            held_dat = bus.outData_C;
            held_tag = bus.out_tag;
            if (bus.out_valid && !bus.out_ready) stall_cnt++;
            if (bus.in_valid && bus.in_ready)
                sb.push_back('{ref_mul(bus.inData_A, bus.inData_B, bus.in_signed), bus.in_tag, cyc, stall_cnt});
        end
        cyc++;
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [TW-1:0] t);
        bit done;
        done          = 1'b0;
        bus.inData_A  = a;
        bus.inData_B  = b;
        bus.in_signed = s;
        bus.in_tag    = t;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) chk(1'b0, "accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_rand();
        send(W'($urandom), W'($urandom), 1'($urandom), TW'($urandom));
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 500 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk(sb.size() == 0, name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.inData_A  = '0;
        bus.inData_B  = '0;
        bus.in_signed = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(bus.out_valid == 1'b0, "rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk(bus.outData_C == 16'h0000, "rst_outData_C", 32'(bus.outData_C), 32'h0);
        chk(bus.in_ready == 1'b0, "rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(bus.in_ready == 1'b1, "post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Largest unsigned operands
        send(8'hFF, 8'hFF, 1'b0, 4'd3);
        drain("drain_unsigned");
        chk(last_out == 16'hFE01, "ff_times_ff", 32'(last_out), 32'hFE01);

        // Signed corners, back-to-back
        send(8'h80, 8'h80, 1'b1, 4'd1);
        send(8'hFF, 8'h7F, 1'b1, 4'd2);
        send(8'h05, 8'hFD, 1'b1, 4'd3);
        drain("drain_signed");
        chk(last_out == 16'hFFF1, "five_times_m3", 32'(last_out), 32'hFFF1);

        // Consumer stall while streaming
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand();
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Reset with operations in flight
        for (int i = 0; i < 3; i++) send_rand();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(bus.out_valid == 1'b0, "mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(8'd12, 8'd10, 1'b0, 4'd5);
        drain("drain_after_rst");
        chk(last_out == 16'h0078, "twelve_times_ten", 32'(last_out), 32'h0078);

        // Randomized traffic with random bubbles and back-pressure
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send_rand();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 9) < 7);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain("drain_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
